pulse_train_gen: RTL

Generates a programmable train of one-cycle enable pulses: a configurable number of pulses spaced a configurable number of clock cycles apart, or a continuous train.
Sits directly upstream of the clock-enable delay stage and drives its start input, so each train pulse launches one delayed enable.
Configuration is latched at start; the train can be aborted at any time. Busy/done status goes to the controlling sequencer.

---
 rtl/pulse_train_gen_if.sv | 33 +++
 rtl/pulse_train_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pulse_train_gen_if.sv
// ============================================================================
// Module      : pulse_train_gen_if
// Description : Control/status bundle between a sequencer and pulse_train_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_train_gen_if #(
    parameter int PERIOD_WIDTH_P = 16,
    parameter int COUNT_WIDTH_P  = 8
) ();
    logic                      start;
    logic                      stop;
    logic [PERIOD_WIDTH_P-1:0] cr_period;
    logic [COUNT_WIDTH_P-1:0]  cr_count;
    logic                      pulse_out;
    logic [COUNT_WIDTH_P-1:0]  pulse_index;
    logic                      busy;
    logic                      done;
    logic                      start_err;

    modport master (
        output start, stop, cr_period, cr_count,
        input  pulse_out, pulse_index, busy, done, start_err
    );

    modport slave (
        input  start, stop, cr_period, cr_count,
        output pulse_out, pulse_index, busy, done, start_err
    );
endinterface

`default_nettype wire

// File: rtl/pulse_train_gen.sv
// ============================================================================
// Module      : pulse_train_gen
// Description : Programmable train of one-cycle pulses (finite or continuous).
//               Optional macro PULSE_TRAIN_RETRIGGER_EN lets start restart a
//               running train.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_train_gen #(
    parameter int PERIOD_WIDTH_P = 16,
    parameter int COUNT_WIDTH_P  = 8
) (
    input wire               clk,
    input wire               rst,
    pulse_train_gen_if.slave ctrl
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    logic [PERIOD_WIDTH_P-1:0] r_period;
    logic [COUNT_WIDTH_P-1:0]  r_count;
    logic [PERIOD_WIDTH_P-1:0] r_cnt;
    logic [COUNT_WIDTH_P-1:0]  r_index;
    logic                      r_pulse;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;

    logic [PERIOD_WIDTH_P-1:0] w_cnt_nxt;
    logic                      w_last;
    logic                      w_cfg_ok;
    logic                      w_retrig;
    logic                      w_retrig_err;

    assign w_cfg_ok  = (ctrl.cr_period != '0);
    assign w_cnt_nxt = (r_cnt == r_period - PERIOD_WIDTH_P'(1)) ? '0
                                                                : r_cnt + PERIOD_WIDTH_P'(1);
    assign w_last    = (r_count != '0) && (r_index == r_count - COUNT_WIDTH_P'(1));

`ifdef PULSE_TRAIN_RETRIGGER_EN
    assign w_retrig     = ctrl.start &&  w_cfg_ok;
    assign w_retrig_err = ctrl.start && !w_cfg_ok;
`else
    assign w_retrig     = 1'b0;
    assign w_retrig_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_period <= '0;
            r_count  <= '0;
            r_cnt    <= '0;
            r_index  <= '0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // stop has priority over start, and start_err too
                    if (ctrl.start && !ctrl.stop) begin
                        if (w_cfg_ok) begin
                            r_state  <= ST_RUN;
                            r_period <= ctrl.cr_period;
                            r_count  <= ctrl.cr_count;
                            r_cnt    <= '0;
                            r_index  <= '0;
                            r_pulse  <= 1'b1;
                            r_busy   <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (ctrl.stop) begin
                        r_state <= ST_IDLE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_retrig) begin
                        r_period <= ctrl.cr_period;
                        r_count  <= ctrl.cr_count;
                        r_cnt    <= '0;
                        r_index  <= '0;
                        r_pulse  <= 1'b1;
                    end else begin
                        if (w_retrig_err) begin
                            r_err <= 1'b1;
                        end
                        if (r_pulse && w_last) begin
                            r_state <= ST_IDLE;
                            r_pulse <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt   <= w_cnt_nxt;
                            r_pulse <= (w_cnt_nxt == '0);
                            if (r_pulse) begin
                                r_index <= r_index + COUNT_WIDTH_P'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A stop arriving in a pulse cycle must kill that pulse, so gate it here.
    assign ctrl.pulse_out   = r_pulse && !ctrl.stop;
    assign ctrl.pulse_index = r_index;
    assign ctrl.busy        = r_busy;
    assign ctrl.done        = r_done;
    assign ctrl.start_err   = r_err;

endmodule

`default_nettype wire
